ntt_stage_seq: RTL and testbench

//  Sequences one radix-2 Cooley-Tukey NTT stage through the fixed-latency butterfly pipeline.

---
 rtl/ntt_pkg.sv | 20 ++
 rtl/ntt_valid_delay.sv | 31 +++
 rtl/ntt_stage_seq.sv | 199 +++++++++++++++++++
 tb/tb_ntt_stage_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT stage sequencer: default sizes, FSM state type
// and address field types.
package ntt_pkg;

  localparam int LOGN_DEF    = 8;
  localparam int N_DEF       = 1 << LOGN_DEF;
  localparam int LATENCY_DEF = 4;
  localparam int SW_DEF      = $clog2(LOGN_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef logic [LOGN_DEF-1:0] addr_t;
  typedef logic [LOGN_DEF-2:0] tw_t;

endpackage

// File: rtl/ntt_valid_delay.sv
// Fixed-depth shift line carrying {valid, addr_a, addr_b} from read issue to
// write-back; asynchronous reset clears every stage so no stale write survives.
module ntt_valid_delay #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] line_q [DEPTH];

  // shift register, one stage per pipeline cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= {W{1'b0}};
      end
    end else begin
      line_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  assign q_o = line_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_seq.sv
// Radix-2 Cooley-Tukey NTT stage sequencer: issues butterfly read pairs and
// twiddle indices, then replays addresses as write-backs LATENCY cycles later.
// Optional cycle counter output perf_cycles when NTT_SEQ_PERF_EN is defined.
module ntt_stage_seq
  import ntt_pkg::*;
#(
  parameter int LOGN    = LOGN_DEF,
  parameter int LATENCY = LATENCY_DEF,
  parameter int SW      = SW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SW-1:0]   stage,
  input  logic            stall,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
`ifdef NTT_SEQ_PERF_EN
  ,
  output logic [15:0]     perf_cycles
`endif
);

  localparam int HALF_N = 1 << (LOGN - 1);
  localparam int CW     = $clog2(LATENCY + 1) + 1;
  localparam int DW     = 1 + 2 * LOGN;
  localparam logic [LOGN-2:0] J_LAST = (LOGN-1)'(HALF_N - 1);

  seq_state_t      state_q, state_d;
  logic [LOGN-2:0] j_q, j_d;
  logic [SW-1:0]   s_q, s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_en_q, rd_en_d;
  logic [LOGN-1:0] rd_a_q, rd_a_d;
  logic [LOGN-1:0] rd_b_q, rd_b_d;
  logic [LOGN-2:0] tw_q, tw_d;

  logic [LOGN-1:0] half_s, pos_s, grp_s, a_s, b_s;
  logic [LOGN-2:0] tw_s;
  logic [SW-1:0]   tw_shamt_s;
  logic            stage_ok_s;
  logic [DW-1:0]   dl_in_s, dl_out_s;

  assign stage_ok_s = (32'(stage) < LOGN);

  // butterfly address generation for pair j of stage s
  always_comb begin
    half_s     = LOGN'(1'b1) << s_q;
    pos_s      = {1'b0, j_q} & (half_s - LOGN'(1'b1));
    grp_s      = {1'b0, j_q} >> s_q;
    a_s        = ((grp_s << s_q) << 1'b1) + pos_s;
    b_s        = a_s + half_s;
    tw_shamt_s = SW'(LOGN - 1) - s_q;
    tw_s       = pos_s[LOGN-2:0] << tw_shamt_s;
  end

  // FSM next-state and registered-output next values
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    tw_d    = tw_q;
    // wr_en comes straight from the delay line, so it is already counted here
    cnt_d   = cnt_q + CW'(rd_en_q) - CW'(wr_en);
    case (state_q)
      IDLE: begin
        if (start && stage_ok_s) begin
          state_d = ISSUE;
          s_d     = stage;
          j_d     = {(LOGN-1){1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        busy_d = 1'b1;
        if (!stall) begin
          rd_en_d = 1'b1;
          rd_a_d  = a_s;
          rd_b_d  = b_s;
          tw_d    = tw_s;
          j_d     = j_q + (LOGN-1)'(1'b1);
          if (j_q == J_LAST) begin
            state_d = DRAIN;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        busy_d = 1'b1;
        if (cnt_d == {CW{1'b0}}) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      j_q     <= {(LOGN-1){1'b0}};
      s_q     <= {SW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= {LOGN{1'b0}};
      rd_b_q  <= {LOGN{1'b0}};
      tw_q    <= {(LOGN-1){1'b0}};
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
    end
  end

  assign dl_in_s = {rd_en_q, rd_a_q, rd_b_q};

  ntt_valid_delay #(
    .W     (DW),
    .DEPTH (LATENCY)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .d_i   (dl_in_s),
    .q_o   (dl_out_s)
  );

  assign {wr_en, wr_addr_a, wr_addr_b} = dl_out_s;

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_addr   = tw_q;

`ifdef NTT_SEQ_PERF_EN
  logic [15:0] perf_q, perf_d;

  // run-length counter: restarts on accepted start, saturates, holds in IDLE
  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE && start && stage_ok_s) begin
      perf_d = 16'h0000;
    end else if (state_q != IDLE && perf_q != 16'hFFFF) begin
      perf_d = perf_q + 16'h0001;
    end else begin
      perf_d = perf_q;
    end
  end

  // perf counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= 16'h0000;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_ntt_stage_seq.sv
// Directed bench for ntt_stage_seq (LOGN=8, LATENCY=4, stage port widened to 4 bits).
module tb_ntt_stage_seq;

  localparam int LOGN    = 8;
  localparam int LATENCY = 4;
  localparam int SW      = 4;
  localparam int MAXC    = 160;

  logic            clk;
  logic            reset;
  logic            start;
  logic [SW-1:0]   stage;
  logic            stall;
  logic            busy, done, rd_en, wr_en;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOGN-2:0] tw_addr;
`ifdef NTT_SEQ_PERF_EN
  logic [15:0]     perf_cycles;
`endif

  ntt_stage_seq #(.LOGN(LOGN), .LATENCY(LATENCY), .SW(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stage     (stage),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
`ifdef NTT_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int lg_rd [0:MAXC];
  int lg_ra [0:MAXC];
  int lg_rb [0:MAXC];
  int lg_wr [0:MAXC];
  int lg_wa [0:MAXC];
  int lg_wb [0:MAXC];
  int lg_busy [0:MAXC];
  int iss_a [0:127];
  int iss_b [0:127];
  int iss_tw [0:127];
  int iss_cyc [0:127];
  int n_iss, first_wr, last_wr, last_rd, done_cyc, n_done;

  typedef struct {
    int stg;
    int j;
    int a;
    int b;
    int tw;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle 0 = the cycle after the edge that samples start; inputs for edge c are
  // set at the preceding negedge, outputs of cycle c are sampled at its negedge.
  task automatic run_stage(input int stg, input int st_lo, input int st_hi, input int spur_c);
    n_iss = 0; first_wr = -1; last_wr = -1; last_rd = -1; done_cyc = -1; n_done = 0;
    for (int c = 0; c <= MAXC; c++) begin
      lg_rd[c] = 0; lg_ra[c] = 0; lg_rb[c] = 0; lg_wr[c] = 0;
      lg_wa[c] = 0; lg_wb[c] = 0; lg_busy[c] = 0;
    end
    @(negedge clk);
    start = 1'b1; stage = SW'(stg); stall = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lg_busy[0] = int'(busy);
    lg_rd[0]   = int'(rd_en);
    for (int c = 1; c <= MAXC; c++) begin
      stall = (c >= st_lo && c <= st_hi);
      start = (c == spur_c);
      if (c == spur_c) stage = 4'd3;
      @(negedge clk);
      lg_rd[c] = int'(rd_en); lg_ra[c] = int'(rd_addr_a); lg_rb[c] = int'(rd_addr_b);
      lg_wr[c] = int'(wr_en); lg_wa[c] = int'(wr_addr_a); lg_wb[c] = int'(wr_addr_b);
      lg_busy[c] = int'(busy);
      if (rd_en) begin
        if (n_iss < 128) begin
          iss_a[n_iss] = int'(rd_addr_a); iss_b[n_iss] = int'(rd_addr_b);
          iss_tw[n_iss] = int'(tw_addr); iss_cyc[n_iss] = c;
        end
        n_iss++;
        last_rd = c;
      end
      if (wr_en) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    start = 1'b0; stall = 1'b0; stage = 4'd0;
  endtask

  task automatic check_timing(input string tag, input int exp_last_rd, input int exp_done);
    int errs;
    chk({tag, "_n_issue"}, n_iss, 128);
    chk({tag, "_first_rd"}, (n_iss > 0) ? iss_cyc[0] : -1, 1);
    chk({tag, "_last_rd"}, last_rd, exp_last_rd);
    chk({tag, "_first_wr"}, first_wr, 1 + LATENCY);
    chk({tag, "_last_wr"}, last_wr, exp_last_rd + LATENCY);
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_busy_c0"}, lg_busy[0], 0);
    chk({tag, "_busy_done"}, lg_busy[exp_done], 1);
    chk({tag, "_busy_after"}, lg_busy[exp_done + 1], 0);
    errs = 0;
    for (int c = 1; c <= LATENCY; c++) errs += lg_wr[c];
    for (int c = 1; c + LATENCY <= MAXC; c++) begin
      if (lg_wr[c + LATENCY] != lg_rd[c]) errs++;
      else if (lg_rd[c] != 0 && (lg_wa[c + LATENCY] != lg_ra[c] || lg_wb[c + LATENCY] != lg_rb[c])) errs++;
    end
    chk({tag, "_wr_delay_errs"}, errs, 0);
`ifdef NTT_SEQ_PERF_EN
    chk({tag, "_perf"}, int'(perf_cycles), exp_done + 1);
`endif
  endtask

  initial begin
    int errs;
    vecs[0] = '{0, 0, 0, 1, 0};
    vecs[1] = '{0, 1, 2, 3, 0};
    vecs[2] = '{0, 127, 254, 255, 0};
    vecs[3] = '{7, 0, 0, 128, 0};
    vecs[4] = '{7, 1, 1, 129, 1};
    vecs[5] = '{7, 127, 127, 255, 127};
    vecs[6] = '{2, 5, 9, 13, 32};
    vecs[7] = '{1, 3, 5, 7, 64};
    vecs[8] = '{6, 100, 164, 228, 72};

    reset = 1'b1; start = 1'b0; stage = 4'd0; stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_addr_or", int'(rd_addr_a | rd_addr_b | wr_addr_a | wr_addr_b | {1'b0, tw_addr}), 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_stage(vecs[i].stg, 1000, 0, -1);
      check_timing($sformatf("vec%0d", i), 128, 133);
      chk($sformatf("vec%0d_a", i), iss_a[vecs[i].j], vecs[i].a);
      chk($sformatf("vec%0d_b", i), iss_b[vecs[i].j], vecs[i].b);
      chk($sformatf("vec%0d_tw", i), iss_tw[vecs[i].j], vecs[i].tw);
    end

    // stall sampled at edges 3..5
    run_stage(0, 3, 5, -1);
    check_timing("stall", 131, 136);
    chk("stall_rd_gap", lg_rd[3] + lg_rd[4] + lg_rd[5], 0);
    chk("stall_rd_c2", lg_rd[2], 1);
    chk("stall_rd_c6", lg_rd[6], 1);
    chk("stall_wr_gap", lg_wr[7] + lg_wr[8] + lg_wr[9], 0);
    chk("stall_j2_cyc", iss_cyc[2], 6);
    chk("stall_j2_a", iss_a[2], 4);

    // start while busy must not restart
    run_stage(0, 1000, 0, 20);
    check_timing("spur", 128, 133);
    chk("spur_last_a", iss_a[127], 254);

    // out-of-range stage in IDLE
    @(negedge clk);
    start = 1'b1; stage = 4'd8;
    @(negedge clk);
    start = 1'b0; stage = 4'd0;
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      errs += int'(busy) + int'(rd_en) + int'(wr_en) + int'(done);
      @(negedge clk);
    end
    chk("bad_stage_idle", errs, 0);

    // reset during ISSUE
    @(negedge clk);
    start = 1'b1; stage = 4'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    chk("midrst_active", int'(rd_en), 1);
    reset = 1'b1;
    #1;
    chk("midrst_outs", int'(rd_en) + int'(busy) + int'(wr_en) + int'(done), 0);
    chk("midrst_addr", int'(rd_addr_a | rd_addr_b | wr_addr_a | wr_addr_b), 0);
    @(negedge clk);
    reset = 1'b0;
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      errs += int'(wr_en) + int'(rd_en) + int'(busy);
    end
    chk("midrst_quiet", errs, 0);

    run_stage(0, 1000, 0, -1);
    check_timing("post_rst", 128, 133);
    chk("post_rst_a1", iss_a[1], 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
